// File: rtl/mux_2x1_8bits_pkg.sv
// Shared constants and types for the two-lane byte un-striping merger.
// Lane numbering and default sizes match the companion 1x2 striping demux.
package mux_2x1_8bits_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;

    // The lane whose byte is next in the merged stream.
    typedef enum logic {
        WAIT_L0 = LANE0,
        WAIT_L1 = LANE1
    } lane_sel_t;

endpackage

// File: rtl/mux_2x1_8bits_lane_fifo.sv
// Per-lane receive FIFO: registered storage, combinational head, count-based flags.
// Pushes while full and pops while empty are ignored.
module lane_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mux_2x1_8bits.sv
// Two-lane byte merger: buffers each lane and re-interleaves L0, L1, L0, L1 in strict order.
// Optional sticky overflow flag on err when MUX_OVF_ERR_EN is defined.
module mux_2x1_8bits
    import mux_2x1_8bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validIn0,
    input  logic [WIDTH-1:0] data_in0,
    input  logic             validIn1,
    input  logic [WIDTH-1:0] data_in1,
    output logic             ready0,
    output logic             ready1,
    output logic             outValid,
    output logic [WIDTH-1:0] data_out,
    output logic             err
);

    lane_sel_t        lane_sel;
    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] head1;
    logic             empty0;
    logic             empty1;
    logic             full0;
    logic             full1;
    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;

    assign ready0 = !full0;
    assign ready1 = !full1;
    assign push0  = validIn0 && ready0;
    assign push1  = validIn1 && ready1;

    // Only the lane in turn may pop; the other lane waits even if it has data.
    assign pop0 = (lane_sel == WAIT_L0) && !empty0;
    assign pop1 = (lane_sel == WAIT_L1) && !empty1;

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .din   (data_in0),
        .pop   (pop0),
        .dout  (head0),
        .empty (empty0),
        .full  (full0)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .din   (data_in1),
        .pop   (pop1),
        .dout  (head1),
        .empty (empty1),
        .full  (full1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_sel <= WAIT_L0;
            outValid <= 1'b0;
            data_out <= '0;
        end else begin
            case (lane_sel)
                WAIT_L0: begin
                    if (pop0) begin
                        data_out <= head0;
                        outValid <= 1'b1;
                        lane_sel <= WAIT_L1;
                    end else begin
                        outValid <= 1'b0;
                    end
                end
                WAIT_L1: begin
                    if (pop1) begin
                        data_out <= head1;
                        outValid <= 1'b1;
                        lane_sel <= WAIT_L0;
                    end else begin
                        outValid <= 1'b0;
                    end
                end
                default: begin
                    lane_sel <= WAIT_L0;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_OVF_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((validIn0 && !ready0) || (validIn1 && !ready1)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_2x1_8bits.sv
// Bench for mux_2x1_8bits: directed scenarios plus random traffic against a queue-based model.
// Handshake: a lane byte is taken when validIn_k && ready_k at posedge; outValid marks a merged byte.
module tb_mux_2x1_8bits;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             validIn0;
    logic [WIDTH-1:0] data_in0;
    logic             validIn1;
    logic [WIDTH-1:0] data_in1;
    logic             ready0;
    logic             ready1;
    logic             outValid;
    logic [WIDTH-1:0] data_out;
    logic             err;

    int checks = 0;
    int errors = 0;

    mux_2x1_8bits #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .validIn0 (validIn0),
        .data_in0 (data_in0),
        .validIn1 (validIn1),
        .data_in1 (data_in1),
        .ready0   (ready0),
        .ready1   (ready1),
        .outValid (outValid),
        .data_out (data_out),
        .err      (err)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each lane is a bounded queue; the merged stream takes the head of the lane in turn.
    logic [WIDTH-1:0] m_q0[$];
    logic [WIDTH-1:0] m_q1[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               m_turn;
    bit               m_valid;
    bit               m_err;
    bit               live = 1'b0;
    bit               acc0;
    bit               acc1;
    logic [WIDTH-1:0] m_data;

    always @(posedge clk) begin
        if (reset) begin
            m_q0.delete();
            m_q1.delete();
            m_turn  = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            m_err   = 1'b0;
            live    = 1'b1;
        end else begin
            acc0 = validIn0 && (m_q0.size() < DEPTH);
            acc1 = validIn1 && (m_q1.size() < DEPTH);
`ifdef MUX_OVF_ERR_EN
            if ((validIn0 && !acc0) || (validIn1 && !acc1)) m_err = 1'b1;
`endif
            m_valid = 1'b0;
            if (!m_turn && m_q0.size() > 0) begin
                m_data  = m_q0.pop_front();
                m_valid = 1'b1;
                m_turn  = 1'b1;
                exp_q.push_back(m_data);
            end else if (m_turn && m_q1.size() > 0) begin
                m_data  = m_q1.pop_front();
                m_valid = 1'b1;
                m_turn  = 1'b0;
                exp_q.push_back(m_data);
            end
            if (acc0) m_q0.push_back(data_in0);
            if (acc1) m_q1.push_back(data_in1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (live) begin
            check("out_valid", outValid, m_valid);
            check("data_out_hold", data_out, m_data);
            check("ready0", ready0, m_q0.size() < DEPTH);
            check("ready1", ready1, m_q1.size() < DEPTH);
            check("err", err, m_err);
            if (outValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected nothing at %0t", data_out, $time);
                end else begin
                    check("merge_order", data_out, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit v0, input logic [WIDTH-1:0] d0,
                       input bit v1, input logic [WIDTH-1:0] d1);
        validIn0 = v0;
        data_in0 = d0;
        validIn1 = v1;
        data_in1 = d1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle(n);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        validIn0 = 1'b0;
        data_in0 = '0;
        validIn1 = 1'b0;
        data_in1 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset values directly after release.
        check("reset_out_valid", outValid, 1'b0);
        check("reset_data_out", data_out, 8'h00);
        check("reset_err", err, 1'b0);
        check("reset_ready0", ready0, 1'b1);
        check("reset_ready1", ready1, 1'b1);

        // Ordered merge A0..A5 on alternating lanes.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) cyc(1'b1, 8'hA0 + 8'(i), 1'b0, '0);
            else            cyc(1'b0, '0, 1'b1, 8'hA0 + 8'(i));
        end
        idle(4);

        // Lane skew: lane 1 arrives late, lane 0 must wait its turn.
        cyc(1'b1, 8'h11, 1'b0, '0);
        cyc(1'b1, 8'h33, 1'b0, '0);
        idle(5);
        cyc(1'b0, '0, 1'b1, 8'h22);
        cyc(1'b0, '0, 1'b1, 8'h44);
        idle(4);

        // Overflow on lane 0 with lane 1 idle.
        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 8'h11 + 8'(i), 1'b0, '0);
        idle(3);
        do_reset(1);

        // Reset in the middle of buffered traffic.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h50 + 8'(i), 1'b1, 8'h60 + 8'(i));
        do_reset(1);
        cyc(1'b1, 8'hAB, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 8'hCD);
        idle(4);

        // Steady streaming: simultaneous push and pop on the same FIFO.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) cyc(1'b1, 8'hC0 + 8'(i), 1'b0, '0);
            else            cyc(1'b0, '0, 1'b1, 8'hC0 + 8'(i));
        end
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'hD0 + 8'(i), 1'b1, 8'hE0 + 8'(i));
        idle(4);
        do_reset(1);

        // Random traffic with varying lane activity and occasional resets.
        for (int i = 0; i < 400; i++) begin
            int p0;
            int p1;
            p0 = (i < 200) ? 50 : 85;
            p1 = (i < 200) ? 50 : 25;
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1);
            end else begin
                cyc($urandom_range(0, 99) < p0, 8'($urandom),
                    $urandom_range(0, 99) < p1, 8'($urandom));
            end
        end

        // Drain: everything the model popped must have been presented.
        idle(20);
        check("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
